// File: rtl/peripheral_endpoint.sv
// Core-to-host peripheral endpoint: capture FIFO for words
// from the core plus a paced send path from the host.
module peripheral_endpoint #(
  parameter int CORE       = 0,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int PTR_BITS   = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            to_peripheral,
  input  logic [DATA_WIDTH-1:0] to_peripheral_data,
  input  logic                  to_peripheral_valid,
  output logic [1:0]            from_peripheral,
  output logic [DATA_WIDTH-1:0] from_peripheral_data,
  output logic                  from_peripheral_valid,
  output logic                  host_rd_valid,
  input  logic                  host_rd_ready,
  output logic [DATA_WIDTH+1:0] host_rd_data,
  input  logic                  host_wr_valid,
  input  logic [1:0]            host_wr_code,
  input  logic [DATA_WIDTH-1:0] host_wr_data,
  output logic                  host_wr_ready,
  output logic [PTR_BITS:0]     fifo_count,
  output logic [15:0]           overflow_count,
  input  logic                  report
);

  localparam int CW = PTR_BITS + 1;
  localparam int EW = DATA_WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [1:0]            code_q, code_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [31:0]           sent_q, sent_d;

  logic [EW-1:0]       mem_q [FIFO_DEPTH];
  logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [15:0]         ovf_q, ovf_d;

  logic full, push, pop, drop;

  always_comb begin
    full = (count_q == CW'(FIFO_DEPTH));
    pop  = (count_q != '0) && host_rd_ready;
    // a full FIFO still takes a word when the head leaves this cycle
    push = to_peripheral_valid && (!full || pop);
    drop = to_peripheral_valid && full && !pop;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_BITS'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_BITS'(1) : wr_ptr_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    if (pop && !push) count_d = count_q - CW'(1);
    ovf_d = ovf_q;
    if (drop && ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      if (push) mem_q[wr_ptr_q] <= {to_peripheral, to_peripheral_data};
    end
  end

  assign host_rd_valid  = (count_q != '0);
  assign host_rd_data   = mem_q[rd_ptr_q];
  assign fifo_count     = count_q;
  assign overflow_count = ovf_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      code_q  <= '0;
      data_q  <= '0;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      data_q  <= data_d;
      sent_q  <= sent_d;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    data_d  = data_q;
    sent_d  = sent_q;
    unique case (state_q)
      IDLE: begin
        if (host_wr_valid) begin
          state_d = SEND;
          code_d  = host_wr_code;
          data_d  = host_wr_data;
        end
      end
      SEND: begin
        state_d = GAP;
        sent_d  = sent_q + 32'd1;
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    from_peripheral_valid = (state_q == SEND);
    host_wr_ready         = (state_q == IDLE);
    from_peripheral       = code_q;
    from_peripheral_data  = data_q;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (report)
      $display("peripheral_endpoint core=%0d fifo_count=%0d overflow_count=%0d sent=%0d",
               CORE, count_q, ovf_q, sent_q);
  end
`endif

endmodule

// File: tb/tb_peripheral_endpoint.sv
// Directed plus randomized bench for peripheral_endpoint,
// checked against a queue-based reference model.
module tb_peripheral_endpoint;
  localparam int DW = 32;
  localparam int DEPTH = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [1:0] to_peripheral = '0;
  logic [DW-1:0] to_peripheral_data = '0;
  logic to_peripheral_valid = 1'b0;
  logic [1:0] from_peripheral;
  logic [DW-1:0] from_peripheral_data;
  logic from_peripheral_valid;
  logic host_rd_valid;
  logic host_rd_ready = 1'b0;
  logic [DW+1:0] host_rd_data;
  logic host_wr_valid = 1'b0;
  logic [1:0] host_wr_code = '0;
  logic [DW-1:0] host_wr_data = '0;
  logic host_wr_ready;
  logic [3:0] fifo_count;
  logic [15:0] overflow_count;
  logic report = 1'b0;

  peripheral_endpoint #(
    .CORE(0), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PTR_BITS(3)
  ) dut (
    .clock(clock), .reset(reset),
    .to_peripheral(to_peripheral),
    .to_peripheral_data(to_peripheral_data),
    .to_peripheral_valid(to_peripheral_valid),
    .from_peripheral(from_peripheral),
    .from_peripheral_data(from_peripheral_data),
    .from_peripheral_valid(from_peripheral_valid),
    .host_rd_valid(host_rd_valid),
    .host_rd_ready(host_rd_ready),
    .host_rd_data(host_rd_data),
    .host_wr_valid(host_wr_valid),
    .host_wr_code(host_wr_code),
    .host_wr_data(host_wr_data),
    .host_wr_ready(host_wr_ready),
    .fifo_count(fifo_count),
    .overflow_count(overflow_count),
    .report(report)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // reference model: queue of {code,data}, drop counter, send timing
  logic [33:0] q[$];
  int ovf = 0;
  int n = 0;
  int last_acc = -10;
  logic [1:0] fp_code = '0;
  logic [31:0] fp_data = '0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("fifo_count", 64'(fifo_count), 64'(q.size()));
    chk("rd_valid", 64'(host_rd_valid), 64'(q.size() != 0));
    if (q.size() != 0) chk("rd_data", 64'(host_rd_data), 64'(q[0]));
    chk("overflow", 64'(overflow_count), 64'(ovf));
    chk("wr_ready", 64'(host_wr_ready), 64'(n >= last_acc + 3));
    chk("fp_valid", 64'(from_peripheral_valid), 64'(n == last_acc + 1));
    chk("fp_code", 64'(from_peripheral), 64'(fp_code));
    chk("fp_data", 64'(from_peripheral_data), 64'(fp_data));
  endtask

  task automatic cyc();
    bit pop, full;
    check_outputs();
    pop  = (q.size() != 0) && host_rd_ready;
    full = (q.size() == DEPTH);
    if (host_wr_valid && n >= last_acc + 3) begin
      last_acc = n;
      fp_code = host_wr_code;
      fp_data = host_wr_data;
    end
    if (pop) void'(q.pop_front());
    if (to_peripheral_valid) begin
      if (!full || pop) q.push_back({to_peripheral, to_peripheral_data});
      else if (ovf < 65535) ovf++;
    end
    @(posedge clock);
    #1;
    n++;
  endtask

  task automatic drain();
    host_rd_ready = 1'b1;
    for (int k = 0; k < 20 && q.size() != 0; k++) cyc();
    host_rd_ready = 1'b0;
    chk("drain_empty", 64'(fifo_count), 64'd0);
  endtask

  initial begin
    int pulses[$];
    int pushes;
    int guard;

    @(posedge clock);
    #1;
    check_outputs();
    reset = 1'b1;

    // single capture on first edge after reset release
    to_peripheral_valid = 1'b1;
    to_peripheral = 2'b00;
    to_peripheral_data = 32'd55;
    cyc();
    to_peripheral_valid = 1'b0;
    chk("single_valid", 64'(host_rd_valid), 64'd1);
    chk("single_data", 64'(host_rd_data), 64'({2'b00, 32'd55}));
    chk("single_count", 64'(fifo_count), 64'd1);
    drain();

    // fill and overflow
    for (int i = 1; i <= 9; i++) begin
      to_peripheral_valid = 1'b1;
      to_peripheral = 2'(i);
      to_peripheral_data = 32'(i);
      cyc();
    end
    to_peripheral_valid = 1'b0;
    chk("fill_count", 64'(fifo_count), 64'd8);
    chk("fill_ovf", 64'(overflow_count), 64'd1);
    host_rd_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("drain_order", 64'(host_rd_data[31:0]), 64'(i));
      cyc();
    end
    host_rd_ready = 1'b0;
    chk("drained", 64'(host_rd_valid), 64'd0);

    // full plus simultaneous pop and push
    for (int i = 1; i <= 8; i++) begin
      to_peripheral_valid = 1'b1;
      to_peripheral_data = 32'(i);
      cyc();
    end
    to_peripheral_data = 32'd10;
    host_rd_ready = 1'b1;
    cyc();
    to_peripheral_valid = 1'b0;
    host_rd_ready = 1'b0;
    chk("full_pp_count", 64'(fifo_count), 64'd8);
    chk("full_pp_ovf", 64'(overflow_count), 64'd1);
    host_rd_ready = 1'b1;
    for (int i = 0; i < 7; i++) cyc();
    chk("last_is_10", 64'(host_rd_data[31:0]), 64'd10);
    cyc();
    host_rd_ready = 1'b0;

    // send held for five cycles
    host_wr_valid = 1'b1;
    host_wr_code = 2'b01;
    host_wr_data = 32'hDEADBEEF;
    for (int k = 0; k < 9; k++) begin
      if (k == 5) host_wr_valid = 1'b0;
      if (from_peripheral_valid) begin
        pulses.push_back(k);
        chk("send_code", 64'(from_peripheral), 64'd1);
        chk("send_data", 64'(from_peripheral_data), 64'hDEADBEEF);
      end
      cyc();
    end
    chk("send_pulses", 64'(pulses.size()), 64'd2);
    if (pulses.size() == 2)
      chk("send_gap", 64'(pulses[1] - pulses[0]), 64'd3);

    // reset during SEND with three entries queued
    for (int i = 0; i < 3; i++) begin
      to_peripheral_valid = 1'b1;
      to_peripheral_data = 32'(100 + i);
      cyc();
    end
    to_peripheral_valid = 1'b0;
    host_wr_valid = 1'b1;
    host_wr_code = 2'b11;
    host_wr_data = 32'h1234_5678;
    cyc();
    host_wr_valid = 1'b0;
    chk("in_send", 64'(from_peripheral_valid), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_fp_valid", 64'(from_peripheral_valid), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_rd_valid", 64'(host_rd_valid), 64'd0);
    chk("rst_wr_ready", 64'(host_wr_ready), 64'd1);
    chk("rst_fp_data", 64'(from_peripheral_data), 64'd0);
    chk("rst_ovf", 64'(overflow_count), 64'd0);
    q.delete();
    ovf = 0;
    fp_code = '0;
    fp_data = '0;
    last_acc = n - 10;
    #2;
    reset = 1'b1;
    @(posedge clock);
    #1;
    n++;

    // pointer wrap with low occupancy
    pushes = 0;
    guard = 0;
    while (pushes < 20 && guard < 500) begin
      to_peripheral_valid = (q.size() < 2) && ($urandom_range(1) == 1);
      to_peripheral = 2'($urandom);
      to_peripheral_data = $urandom;
      host_rd_ready = ($urandom_range(1) == 1);
      host_wr_valid = ($urandom_range(3) == 0);
      host_wr_code = 2'($urandom);
      host_wr_data = $urandom;
      if (to_peripheral_valid) pushes++;
      cyc();
      guard++;
    end
    chk("wrap_budget", 64'(pushes >= 20), 64'd1);
    to_peripheral_valid = 1'b0;
    host_wr_valid = 1'b0;
    chk("wrap_ovf", 64'(overflow_count), 64'd0);
    drain();

    // free-running random traffic including overflow
    for (int k = 0; k < 300; k++) begin
      to_peripheral_valid = ($urandom_range(3) != 0);
      to_peripheral = 2'($urandom);
      to_peripheral_data = $urandom;
      host_rd_ready = ($urandom_range(3) == 0);
      host_wr_valid = ($urandom_range(1) == 1);
      host_wr_code = 2'($urandom);
      host_wr_data = $urandom;
      cyc();
    end
    to_peripheral_valid = 1'b0;
    host_wr_valid = 1'b0;
    report = 1'b1;
    cyc();
    report = 1'b0;
    drain();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end
endmodule
